// File: rtl/mem_initiator_pkg.sv
// Shared types and helpers for the hart-side load/store initiator.
//   XLEN                  : machine word width in bits
//   write_width_t         : byte / halfword / word access size (also the RAM write width)
//   mem_initiator_state_t : initiator sequencing states
//   size_bytes()          : number of bytes covered by an access size
//   is_misaligned()       : natural-alignment check for an access size and address LSBs
package mem_initiator_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      write_byte = 2'd0,
      write_half = 2'd1,
      write_word = 2'd2
   } write_width_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } mem_initiator_state_t;

   function automatic logic [2:0] size_bytes(input write_width_t width);
      case (width)
         write_byte: size_bytes = 3'd1;
         write_half: size_bytes = 3'd2;
         default:    size_bytes = 3'd4;
      endcase
   endfunction

   // Byte accesses are always aligned.
   function automatic logic is_misaligned(input write_width_t width, input logic [1:0] lsb);
      case (width)
         write_half: is_misaligned = lsb[0];
         write_word: is_misaligned = (lsb != 2'b00);
         default:    is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_initiator_load_extend.sv
// Combinational load-result extender.
//   raw      in  XLEN  raw data, right-justified (already shifted by the byte offset)
//   size     in  write_width_t  byte / halfword / word
//   zero_ext in  1     1 = zero-extend, 0 = sign-extend
//   result   out XLEN  extended value
module load_extend
   import mem_initiator_pkg::*;
(
   input  logic [XLEN-1:0] raw,
   input  write_width_t    size,
   input  logic            zero_ext,
   output logic [XLEN-1:0] result
);

   always_comb begin
      result = raw;
      case (size)
         write_byte: begin
            result = zero_ext ? {{(XLEN-8){1'b0}}, raw[7:0]}
                              : {{(XLEN-8){raw[7]}}, raw[7:0]};
         end
         write_half: begin
            result = zero_ext ? {{(XLEN-16){1'b0}}, raw[15:0]}
                              : {{(XLEN-16){raw[15]}}, raw[15:0]};
         end
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/mem_initiator.sv
// Hart-side load/store initiator driving a byte-enabled word RAM with 1-cycle read latency.
// Accepts one request over valid/ready, sequences the RAM port, extends load data and
// returns a one-cycle response pulse. Misaligned accesses fault unless the build defines
// MISALIGNED_SPLIT_EN, in which case they run as sequential byte accesses.
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_store, req_addr, req_size, req_unsigned, req_wdata : request fields
//   resp_valid, resp_rdata, resp_fault : registered completion pulse and result
//   mem_addr, mem_wwidth, mem_wenable, mem_wdata, mem_rdata : RAM port
module mem_initiator
   import mem_initiator_pkg::*;
#(
   parameter int unsigned ADDR_W     = XLEN,
   parameter bit          IDLE_READY = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [XLEN-1:0] req_addr,
   input  write_width_t    req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_fault,
   output logic [XLEN-1:0] mem_addr,
   output write_width_t    mem_wwidth,
   output logic            mem_wenable,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SplitEn = 1'b1;
`else
   localparam bit SplitEn = 1'b0;
`endif

   // Bits above ADDR_W are never presented to the RAM.
   localparam logic [XLEN-1:0] AddrMask = (ADDR_W >= XLEN) ? {XLEN{1'b1}}
                                        : ((XLEN'(1) << ADDR_W) - XLEN'(1));

   mem_initiator_state_t state_q;
   logic                 store_q;
   logic [XLEN-1:0]      addr_q;
   write_width_t         size_q;
   logic                 unsigned_q;
   logic [XLEN-1:0]      wdata_q;
   logic                 split_q;
   logic [1:0]           idx_q;
   logic [XLEN-1:0]      asm_q;

   logic [1:0]           idx_inc;
   logic                 last_byte;
   logic                 req_misaligned;
   logic [XLEN-1:0]      asm_next;
   logic [XLEN-1:0]      ext_raw;
   logic [XLEN-1:0]      ext_data;
   logic [XLEN-1:0]      next_byte_addr;

   assign req_ready = (state_q == StIdle) && !reset && (IDLE_READY || !resp_valid);

   assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);
   assign idx_inc        = idx_q + 2'd1;
   assign last_byte      = ({1'b0, idx_q} == (size_bytes(size_q) - 3'd1));
   assign next_byte_addr = (addr_q + XLEN'(idx_inc)) & AddrMask;

   // Split loads collect one byte per WAIT into the assembly register.
   always_comb begin
      asm_next = asm_q;
      asm_next[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
   end

   assign ext_raw = split_q ? asm_next : mem_rdata;

   load_extend u_load_extend (
      .raw      (ext_raw),
      .size     (size_q),
      .zero_ext (unsigned_q),
      .result   (ext_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         resp_valid  <= 1'b0;
         resp_fault  <= 1'b0;
         resp_rdata  <= '0;
         mem_wenable <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wwidth  <= write_word;
         store_q     <= 1'b0;
         addr_q      <= '0;
         size_q      <= write_word;
         unsigned_q  <= 1'b0;
         wdata_q     <= '0;
         split_q     <= 1'b0;
         idx_q       <= '0;
         asm_q       <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               resp_valid  <= 1'b0;
               resp_fault  <= 1'b0;
               mem_wenable <= 1'b0;
               if (req_valid && req_ready) begin
                  store_q    <= req_store;
                  addr_q     <= req_addr;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  wdata_q    <= req_wdata;
                  split_q    <= req_misaligned && SplitEn;
                  idx_q      <= '0;
                  asm_q      <= '0;
                  if (req_misaligned && !SplitEn) begin
                     // Fault without touching the RAM port.
                     state_q    <= StResp;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state_q     <= StIssue;
                     mem_addr    <= req_addr & AddrMask;
                     mem_wenable <= req_store;
                     if (req_misaligned) begin
                        mem_wwidth <= write_byte;
                        mem_wdata  <= {{(XLEN-8){1'b0}}, req_wdata[7:0]};
                     end else begin
                        mem_wwidth <= req_size;
                        mem_wdata  <= req_wdata;
                     end
                  end
               end
            end

            StIssue: begin
               mem_wenable <= 1'b0;
               if (store_q) begin
                  if (split_q && !last_byte) begin
                     idx_q       <= idx_inc;
                     mem_addr    <= next_byte_addr;
                     mem_wdata   <= {{(XLEN-8){1'b0}}, wdata_q[{idx_inc, 3'b000} +: 8]};
                     mem_wenable <= 1'b1;
                  end else begin
                     state_q    <= StResp;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b0;
                     resp_rdata <= '0;
                  end
               end else begin
                  state_q <= StWait;
               end
            end

            StWait: begin
               if (split_q) begin
                  asm_q <= asm_next;
                  if (!last_byte) begin
                     idx_q    <= idx_inc;
                     mem_addr <= next_byte_addr;
                     state_q  <= StIssue;
                  end else begin
                     state_q    <= StResp;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b0;
                     resp_rdata <= ext_data;
                  end
               end else begin
                  state_q    <= StResp;
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b0;
                  resp_rdata <= ext_data;
               end
            end

            StResp: begin
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               state_q    <= StIdle;
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed testbench for mem_initiator with a byte-array RAM and a transaction-level model.
module tb_mem_initiator;
   import mem_initiator_pkg::*;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_store = 1'b0;
   logic [31:0]  req_addr = '0;
   write_width_t req_size = write_word;
   logic         req_unsigned = 1'b0;
   logic [31:0]  req_wdata = '0;
   logic         resp_valid;
   logic [31:0]  resp_rdata;
   logic         resp_fault;
   logic [31:0]  mem_addr;
   write_width_t mem_wwidth;
   logic         mem_wenable;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;

   int checks   = 0;
   int failures = 0;
   bit prev_hold = 1'b0;

   logic [7:0] ram  [256] = '{default: 8'h00};
   logic [7:0] gold [256] = '{default: 8'h00};

   always #5 clock = ~clock;

   mem_initiator dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_store    (req_store),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_fault   (resp_fault),
      .mem_addr     (mem_addr),
      .mem_wwidth   (mem_wwidth),
      .mem_wenable  (mem_wenable),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   function automatic int nbytes(input write_width_t w);
      if (w == write_byte) return 1;
      if (w == write_half) return 2;
      return 4;
   endfunction

   // RAM: byte-enabled writes, 1-cycle read of the 4 bytes starting at mem_addr.
   always @(posedge clock) begin
      if (mem_wenable) begin
         ram[mem_addr[7:0]] <= mem_wdata[7:0];
         if (nbytes(mem_wwidth) > 1) ram[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
         if (nbytes(mem_wwidth) > 2) begin
            ram[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
            ram[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
         end
      end
      mem_rdata <= {ram[mem_addr[7:0] + 8'd3], ram[mem_addr[7:0] + 8'd2],
                    ram[mem_addr[7:0] + 8'd1], ram[mem_addr[7:0]]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit uns);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(gold[8'(a + 32'(i))]) << (8 * i));
      if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic do_req(input string nm, input bit st, input logic [31:0] a,
                         input write_width_t sz, input bit uns, input logic [31:0] wd,
                         input bit has_lit, input logic [31:0] lit, input bit hold);
      int          n, lat, nw, seen, bound;
      bit          mis, split;
      logic [31:0] exp_rd;
      n   = nbytes(sz);
      mis = (sz == write_half && a[0]) || (sz == write_word && a[1:0] != 2'b00);
`ifdef MISALIGNED_SPLIT_EN
      split = mis;
      mis   = 1'b0;
`else
      split = 1'b0;
`endif
      exp_rd = '0;
      nw     = 0;
      if (mis) lat = 1;
      else if (st) begin
         lat = split ? n + 1 : 2;
         nw  = split ? n : 1;
         for (int i = 0; i < n; i++) gold[8'(a + 32'(i))] = wd[8 * i +: 8];
      end else begin
         lat    = split ? 2 * n + 1 : 3;
         exp_rd = model_load(a, n, uns);
      end
      if (has_lit) chk({nm, " model"}, exp_rd, lit);

      @(negedge clock);
      if (prev_hold) chk({nm, " ready after resp"}, 32'(req_ready), 32'd1);
      req_store    = st;
      req_addr     = a;
      req_size     = sz;
      req_unsigned = uns;
      req_wdata    = wd;
      req_valid    = 1'b1;
      bound        = 0;
      while (!req_ready && bound < 20) begin
         @(negedge clock);
         bound++;
      end
      if (!req_ready) begin
         chk({nm, " accept timeout"}, 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         prev_hold = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      if (!hold) req_valid = 1'b0;
      seen = 0;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clock);
         chk($sformatf("%s resp_valid c%0d", nm, c), 32'(resp_valid), 32'(c == lat));
         chk($sformatf("%s req_ready c%0d", nm, c), 32'(req_ready), 32'd0);
         if (mem_wenable) begin
            if (split) begin
               chk($sformatf("%s waddr%0d", nm, seen), mem_addr, a + 32'(seen));
               chk($sformatf("%s wwidth%0d", nm, seen), 32'(mem_wwidth), 32'(write_byte));
               chk($sformatf("%s wbyte%0d", nm, seen), 32'(mem_wdata[7:0]),
                   32'(wd[8 * seen +: 8]));
            end else begin
               chk({nm, " waddr"}, mem_addr, a);
               chk({nm, " wwidth"}, 32'(mem_wwidth), 32'(sz));
               chk({nm, " wdata"}, mem_wdata, wd);
            end
            seen++;
         end
         if (c == lat) begin
            chk({nm, " rdata"}, resp_rdata, exp_rd);
            chk({nm, " fault"}, 32'(resp_fault), 32'(mis));
            if (has_lit) chk({nm, " rdata lit"}, resp_rdata, lit);
         end
      end
      chk({nm, " write pulses"}, 32'(seen), 32'(nw));
      prev_hold = hold;
   endtask

   initial begin
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset resp_fault", 32'(resp_fault), 32'd0);
      chk("reset resp_rdata", resp_rdata, 32'd0);
      chk("reset mem_wenable", 32'(mem_wenable), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset mem_wdata", mem_wdata, 32'd0);
      chk("reset mem_wwidth", 32'(mem_wwidth), 32'(write_word));
      chk("reset req_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("idle req_ready", 32'(req_ready), 32'd1);

      do_req("sw 10",   1'b1, 32'h10, write_word, 1'b0, 32'h87654321, 1'b0, 32'h0, 1'b0);
      do_req("lw 10",   1'b0, 32'h10, write_word, 1'b0, 32'h0, 1'b1, 32'h87654321, 1'b0);
      do_req("sh 12",   1'b1, 32'h12, write_half, 1'b0, 32'h0000FEDC, 1'b0, 32'h0, 1'b0);
      do_req("lh 12",   1'b0, 32'h12, write_half, 1'b0, 32'h0, 1'b1, 32'hFFFFFEDC, 1'b0);
      do_req("lhu 12",  1'b0, 32'h12, write_half, 1'b1, 32'h0, 1'b1, 32'h0000FEDC, 1'b0);
      do_req("lw 10 b", 1'b0, 32'h10, write_word, 1'b0, 32'h0, 1'b1, 32'hFEDC4321, 1'b0);
      do_req("sb 11",   1'b1, 32'h11, write_byte, 1'b0, 32'h000000BA, 1'b0, 32'h0, 1'b0);
      do_req("lb 11",   1'b0, 32'h11, write_byte, 1'b0, 32'h0, 1'b1, 32'hFFFFFFBA, 1'b0);
      do_req("lw 10 c", 1'b0, 32'h10, write_word, 1'b0, 32'h0, 1'b1, 32'hFEDCBA21, 1'b0);
`ifdef MISALIGNED_SPLIT_EN
      do_req("lh 13",   1'b0, 32'h13, write_half, 1'b0, 32'h0, 1'b1, 32'h000000FE, 1'b0);
      do_req("sh 13",   1'b1, 32'h13, write_half, 1'b0, 32'h0000BEEF, 1'b0, 32'h0, 1'b0);
      do_req("lhu 13",  1'b0, 32'h13, write_half, 1'b1, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);
`else
      do_req("lh 13",   1'b0, 32'h13, write_half, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
      do_req("sh 13",   1'b1, 32'h13, write_half, 1'b0, 32'h0000BEEF, 1'b0, 32'h0, 1'b0);
      do_req("lhu 13",  1'b0, 32'h13, write_half, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
`endif
      do_req("sw 21",   1'b1, 32'h21, write_word, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
      do_req("lw 21",   1'b0, 32'h21, write_word, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Back-to-back with req_valid held high.
      do_req("b2b sb",  1'b1, 32'h20, write_byte, 1'b0, 32'h0000005A, 1'b0, 32'h0, 1'b1);
      do_req("b2b lbu", 1'b0, 32'h20, write_byte, 1'b1, 32'h0, 1'b1, 32'h0000005A, 1'b0);

      // Reset during WAIT of an aligned load.
      @(negedge clock);
      req_store    = 1'b0;
      req_addr     = 32'h10;
      req_size     = write_word;
      req_unsigned = 1'b0;
      req_valid    = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst mid resp_valid", 32'(resp_valid), 32'd0);
      chk("rst mid mem_wenable", 32'(mem_wenable), 32'd0);
      chk("rst mid req_ready", 32'(req_ready), 32'd1);
      repeat (3) begin
         @(negedge clock);
         chk("rst mid no resp", 32'(resp_valid), 32'd0);
      end
      do_req("lw after rst", 1'b0, 32'h10, write_word, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Address wrap near the top of the address space.
      do_req("sw wrap", 1'b1, 32'hFFFFFFFE, write_word, 1'b0, 32'h11223344, 1'b0, 32'h0, 1'b0);
      do_req("lw wrap", 1'b0, 32'hFFFFFFFE, write_word, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      do_req("lb ff",   1'b0, 32'hFFFFFFFF, write_byte, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
